// File: rtl/usb_tx_timer_if.sv
// Handshake bundle between the TX controller / bit stuffer (master) and the
// transmit bit/byte timer (slave).
interface usb_tx_timer_if #(
  parameter int unsigned BITS_PER_BYTE = 8
);
  localparam int unsigned BIT_W = $clog2(BITS_PER_BYTE);

  logic             start;
  logic             stop;
  logic             stuff_req;
  logic             busy;
  logic             bit_strobe;
  logic             byte_done;
  logic             load_byte;
  logic [BIT_W-1:0] bit_count;

  modport master (
    output start, stop, stuff_req,
    input  busy, bit_strobe, byte_done, load_byte, bit_count
  );

  modport slave (
    input  start, stop, stuff_req,
    output busy, bit_strobe, byte_done, load_byte, bit_count
  );
endinterface

// File: rtl/usb_tx_timer.sv
// USB full-speed transmit timing: one strobe per bit period, bit position within
// the byte, stuffed-bit hold, per-byte load requests and byte-aligned stop.
module usb_tx_timer #(
  parameter int unsigned CLKS_PER_BIT  = 8,
  parameter int unsigned BITS_PER_BYTE = 8
) (
  input  logic          clk,
  input  logic          n_rst,
  usb_tx_timer_if.slave bus
);
  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam int unsigned BIT_W = $clog2(BITS_PER_BYTE);
  localparam logic [CNT_W-1:0] CLK_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(BITS_PER_BYTE - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state;
  logic [CNT_W-1:0] clk_cnt;
  logic [BIT_W-1:0] bit_cnt;
  logic             stop_pend;
  logic             load_byte;
  logic             bit_strobe;
  logic             byte_done;

  // Decodes of registered state; stuff_req only matters on strobe cycles.
  assign bit_strobe = (state == RUN) && (clk_cnt == CLK_LAST);
  assign byte_done  = bit_strobe && !bus.stuff_req && (bit_cnt == BIT_LAST);

  assign bus.busy       = (state != IDLE);
  assign bus.bit_strobe = bit_strobe;
  assign bus.byte_done  = byte_done;
  assign bus.load_byte  = load_byte;
  assign bus.bit_count  = bit_cnt;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state     <= IDLE;
      clk_cnt   <= '0;
      bit_cnt   <= '0;
      stop_pend <= 1'b0;
      load_byte <= 1'b0;
    end else begin
      load_byte <= 1'b0;
      case (state)
        IDLE: begin
          clk_cnt <= '0;
          bit_cnt <= '0;
          if (bus.start) begin
            state     <= RUN;
            load_byte <= 1'b1;
            // start+stop together: accept and send exactly one byte
            stop_pend <= bus.stop;
          end
        end
        RUN: begin
          if (bus.stop) stop_pend <= 1'b1;
          clk_cnt <= bit_strobe ? '0 : clk_cnt + CNT_W'(1);
          if (bit_strobe && !bus.stuff_req) begin
            if (byte_done) begin
              bit_cnt <= '0;
              if (stop_pend || bus.stop) begin
                state     <= IDLE;
                stop_pend <= 1'b0;
                clk_cnt   <= '0;
              end else begin
                load_byte <= 1'b1;
              end
            end else begin
              bit_cnt <= bit_cnt + BIT_W'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_usb_tx_timer.sv
// Bench for usb_tx_timer: scenario table with per-cycle expected outputs held
// in a scoreboard queue, event tallies against hand-derived timing, and a reset.
module tb_usb_tx_timer;
  localparam int unsigned CPB   = 8;
  localparam int unsigned BPB   = 8;
  localparam int unsigned BIT_W = $clog2(BPB);

  typedef struct packed {
    logic             busy;
    logic             bit_strobe;
    logic             byte_done;
    logic             load_byte;
    logic [BIT_W-1:0] bit_count;
  } exp_t;

  typedef struct {
    string name;
    int    start1, stop_c, stuff_c, start2, ncyc;
    int    n_strobe, n_bd, n_load, last_bd, fall;
  } vec_t;

  logic clk = 1'b0;
  logic n_rst;
  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];
  vec_t tbl[8];

  usb_tx_timer_if #(.BITS_PER_BYTE(BPB)) bus ();

  usb_tx_timer #(.CLKS_PER_BIT(CPB), .BITS_PER_BYTE(BPB)) dut (
    .clk  (clk),
    .n_rst(n_rst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  function automatic exp_t actual();
    exp_t a;
    a.busy       = bus.busy;
    a.bit_strobe = bus.bit_strobe;
    a.byte_done  = bus.byte_done;
    a.load_byte  = bus.load_byte;
    a.bit_count  = bus.bit_count;
    return a;
  endfunction

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, want);
    end
  endtask

  // Expected outputs per cycle, walked at bit-period granularity from the start cycle.
  task automatic predict(input vec_t v);
    bit run;
    bit sp;
    int t0;
    int bp;
    int last_bd;
    exp_t e;
    run = 0; sp = 0; t0 = 0; bp = 0; last_bd = -10;
    for (int c = 0; c < v.ncyc; c++) begin
      e = '0;
      if (run) begin
        e.busy       = 1'b1;
        e.bit_count  = BIT_W'(bp);
        e.load_byte  = (c == t0 + 1) || (c == last_bd + 1);
        e.bit_strobe = ((c - t0) % CPB) == 0;
        if (c == v.stop_c) sp = 1;
        if (e.bit_strobe && c != v.stuff_c) begin
          if (bp == BPB - 1) begin
            e.byte_done = 1'b1;
            bp = 0;
            last_bd = c;
            if (sp) begin run = 0; sp = 0; end
          end else begin
            bp++;
          end
        end
      end else if (c == v.start1 || c == v.start2) begin
        run = 1; t0 = c; bp = 0; sp = (c == v.stop_c);
      end
      exp_q.push_back(e);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    n_rst = 1'b0;
    bus.start = 1'b0; bus.stop = 1'b0; bus.stuff_req = 1'b0;
    repeat (2) @(negedge clk);
    n_rst = 1'b1;
  endtask

  task automatic run_scn(input vec_t v);
    exp_t e;
    exp_t a;
    int n_strobe, n_bd, n_load, last_bd, fall;
    bit prev_busy;
    n_strobe = 0; n_bd = 0; n_load = 0; last_bd = -1; fall = -1; prev_busy = 0;
    do_reset();
    predict(v);
    for (int c = 0; c < v.ncyc; c++) begin
      @(negedge clk);
      bus.start     = (c == v.start1) || (c == v.start2);
      bus.stop      = (c == v.stop_c);
      bus.stuff_req = (c == v.stuff_c);
      #1;
      a = actual();
      e = exp_q.pop_front();
      checks++;
      if (a != e) begin
        errors++;
        $display("FAIL %s cyc%0d: got busy=%0b strb=%0b bd=%0b ld=%0b bc=%0d expected busy=%0b strb=%0b bd=%0b ld=%0b bc=%0d",
                 v.name, c, a.busy, a.bit_strobe, a.byte_done, a.load_byte, a.bit_count,
                 e.busy, e.bit_strobe, e.byte_done, e.load_byte, e.bit_count);
      end
      if (a.bit_strobe) n_strobe++;
      if (a.byte_done) begin n_bd++; last_bd = c; end
      if (a.load_byte) n_load++;
      if (prev_busy && !a.busy && fall < 0) fall = c;
      prev_busy = a.busy;
    end
    chk({v.name, " strobes"}, n_strobe, v.n_strobe);
    chk({v.name, " byte_dones"}, n_bd, v.n_bd);
    chk({v.name, " load_bytes"}, n_load, v.n_load);
    chk({v.name, " last_byte_done"}, last_bd, v.last_bd);
    chk({v.name, " busy_fall"}, fall, v.fall);
  endtask

  initial begin
    exp_t a;
    n_rst = 1'b0;
    bus.start = 1'b0; bus.stop = 1'b0; bus.stuff_req = 1'b0;

    //         name        st1 stop stuf st2 ncyc strb bd ld last fall
    tbl[0] = '{"idle",      -1, -1,  -1, -1,  20,   0, 0, 0,  -1,  -1};
    tbl[1] = '{"single",     0, 10,  -1, -1,  80,   8, 1, 1,  64,  65};
    tbl[2] = '{"stuffed",    0, 10,  24, -1,  90,   9, 1, 1,  72,  73};
    tbl[3] = '{"b2b",        0, 100, -1, -1, 140,  16, 2, 2, 128, 129};
    tbl[4] = '{"start_stop", 0,  0,  -1, -1,  80,   8, 1, 1,  64,  65};
    tbl[5] = '{"stop_at_bd", 0, 64,  -1, -1,  80,   8, 1, 1,  64,  65};
    tbl[6] = '{"busy_start", 0, 10,  -1, 30,  80,   8, 1, 1,  64,  65};
    tbl[7] = '{"restart",    0, 10,  -1, 65, 140,  17, 2, 3, 129,  65};

    for (int i = 0; i < 8; i++) run_scn(tbl[i]);

    // Reset asserted mid-packet must clear every output without waiting for a clock.
    do_reset();
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      bus.start = (c == 0);
    end
    #1;
    a = actual();
    chk("pre_reset busy", int'(a.busy), 1);
    chk("pre_reset bit_count", int'(a.bit_count), 4);
    n_rst = 1'b0;
    #1;
    a = actual();
    chk("mid_reset outputs", int'(a), 0);
    @(negedge clk);
    a = actual();
    chk("held_reset outputs", int'(a), 0);
    n_rst = 1'b1;
    run_scn(tbl[1]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
